wr_arria10_rx_det_align: RTL

WR_ARRIA10_RX_DET_ALIGN -- requirements
Module: wr_arria10_rx_det_align

---
 rtl/wr_arria10_rx_det_align.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/wr_arria10_rx_det_align.sv
// rtl/wr_arria10_rx_det_align.sv - per-lane RX reset / word-align sequencer with deterministic-latency acceptance
// Optional retry/bitslip statistics outputs are built when WR_RX_DET_ALIGN_STATS_EN is defined.
module wr_arria10_rx_det_align #(
   parameter int g_NUM_LANES     = 1,
   parameter int g_DATA_WIDTH    = 8,
   parameter int g_RST_CYCLES    = 16,
   parameter int g_LOCK_WAIT     = 1024,
   parameter int g_ALIGN_TIMEOUT = 4096,
   parameter int g_MAX_RETRIES   = 15
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  enable_i,
   input  logic [g_NUM_LANES-1:0]                rx_is_lockedtodata_i,
   input  logic [g_NUM_LANES*g_DATA_WIDTH/8-1:0] rx_syncstatus_i,
   input  logic [5*g_NUM_LANES-1:0]              rx_bitslipboundarysel_i,
   output logic [g_NUM_LANES-1:0]                rx_digitalreset_o,
   output logic [g_NUM_LANES-1:0]                rx_wa_patternalign_o,
   output logic [g_NUM_LANES-1:0]                rx_ready_o,
   output logic [g_NUM_LANES-1:0]                rx_fail_o,
   output logic [8*g_NUM_LANES-1:0]              rx_retries_o,
   output logic [5*g_NUM_LANES-1:0]              rx_bitslip_o
);

   localparam int c_BYTES   = g_DATA_WIDTH / 8;
   localparam int c_MAX_AB  = (g_LOCK_WAIT > g_ALIGN_TIMEOUT) ? g_LOCK_WAIT : g_ALIGN_TIMEOUT;
   localparam int c_CNT_MAX = (c_MAX_AB > g_RST_CYCLES) ? c_MAX_AB : g_RST_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   localparam logic [c_CNT_W-1:0] c_RST_LAST   = c_CNT_W'(g_RST_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_LOCK_LAST  = c_CNT_W'(g_LOCK_WAIT - 1);
   localparam logic [c_CNT_W-1:0] c_ALIGN_LAST = c_CNT_W'(g_ALIGN_TIMEOUT - 1);
   localparam logic [3:0]         c_MAX_RETRY  = 4'(g_MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET, S_WAIT_LOCK, S_ALIGN, S_CHECK, S_READY, S_FAIL
   } state_t;

   for (genvar l = 0; l < g_NUM_LANES; l++) begin : g_lane
      state_t               state, state_nxt;
      logic [c_CNT_W-1:0]   cnt, cnt_nxt;
      logic [3:0]           retry_cnt, retry_cnt_nxt, retry_inc;
      logic                 locked, synced, retry;
      logic [4:0]           bitslip;
      logic                 dr, pat, rdy, fl;

      assign locked    = rx_is_lockedtodata_i[l];
      assign synced    = &rx_syncstatus_i[l*c_BYTES +: c_BYTES];
      assign bitslip   = rx_bitslipboundarysel_i[5*l +: 5];
      assign retry_inc = retry_cnt + 4'd1;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
         end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_cnt_nxt;
         end
      end

      // cnt is reused per state: reset pulse length, lock dwell, align timeout
      always_comb begin
         state_nxt     = state;
         cnt_nxt       = cnt + c_CNT_W'(1);
         retry_cnt_nxt = retry_cnt;
         retry         = 1'b0;
         if (!enable_i) begin
            state_nxt     = S_RESET;
            cnt_nxt       = '0;
            retry_cnt_nxt = '0;
         end else begin
            case (state)
               S_RESET: begin
                  if (cnt == c_RST_LAST) begin
                     state_nxt = S_WAIT_LOCK;
                     cnt_nxt   = '0;
                  end
               end
               S_WAIT_LOCK: begin
                  if (!locked) begin
                     cnt_nxt = '0;
                  end else if (cnt == c_LOCK_LAST) begin
                     state_nxt = S_ALIGN;
                     cnt_nxt   = '0;
                  end
               end
               S_ALIGN: begin
                  if (!locked) begin
                     state_nxt = S_RESET;
                     cnt_nxt   = '0;
                  end else if (synced) begin
                     state_nxt = S_CHECK;
                     cnt_nxt   = '0;
                  end else if (cnt == c_ALIGN_LAST) begin
                     retry = 1'b1;
                  end
               end
               S_CHECK: begin
                  cnt_nxt = '0;
                  if (!locked)         state_nxt = S_RESET;
                  else if (!bitslip[0]) state_nxt = S_READY;
                  else                 retry = 1'b1;
               end
               S_READY: begin
                  cnt_nxt = '0;
                  if (!locked || !synced) state_nxt = S_RESET;
               end
               S_FAIL: cnt_nxt = '0;
               default: begin
                  state_nxt = S_RESET;
                  cnt_nxt   = '0;
               end
            endcase
         end
         if (retry) begin
            retry_cnt_nxt = retry_inc;
            cnt_nxt       = '0;
            state_nxt     = (retry_inc == c_MAX_RETRY) ? S_FAIL : S_RESET;
         end
      end

      always_comb begin
         dr  = (state == S_RESET) || (state == S_FAIL);
         pat = (state == S_ALIGN) && (cnt == '0);
         rdy = (state == S_READY);
         fl  = (state == S_FAIL);
      end

      assign rx_digitalreset_o[l]    = dr;
      assign rx_wa_patternalign_o[l] = pat;
      assign rx_ready_o[l]           = rdy;
      assign rx_fail_o[l]            = fl;

`ifdef WR_RX_DET_ALIGN_STATS_EN
      logic [7:0] stat_retries;
      logic [4:0] stat_bitslip;
      logic       accept;

      assign accept = enable_i && (state == S_CHECK) && locked && !bitslip[0];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            stat_retries <= '0;
            stat_bitslip <= '0;
         end else begin
            if (!enable_i)
               stat_retries <= '0;
            else if (retry && (stat_retries != 8'hFF))
               stat_retries <= stat_retries + 8'd1;
            if (accept)
               stat_bitslip <= bitslip;
         end
      end

      assign rx_retries_o[8*l +: 8] = stat_retries;
      assign rx_bitslip_o[5*l +: 5] = stat_bitslip;
`else
      logic unused_bitslip;
      assign unused_bitslip         = ^bitslip[4:1];
      assign rx_retries_o[8*l +: 8] = '0;
      assign rx_bitslip_o[5*l +: 5] = '0;
`endif
   end

endmodule
